// File: rtl/alarm_controller_if.sv
// Bundle between the time-of-day counter / user controls and the alarm unit.
interface alarm_if;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       arm;
  logic       set_en;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       set_pm;
  logic       snooze;
  logic       dismiss;
  logic       ring;
  logic       snoozing;
  logic [3:0] snooze_cnt;
  logic       set_err;
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       al_pm;

  modport master (
    output hh, mm, ss, pm, arm, set_en, set_hh, set_mm, set_pm, snooze, dismiss,
    input  ring, snoozing, snooze_cnt, set_err, al_hh, al_mm, al_pm
  );

  modport slave (
    input  hh, mm, ss, pm, arm, set_en, set_hh, set_mm, set_pm, snooze, dismiss,
    output ring, snoozing, snooze_cnt, set_err, al_hh, al_mm, al_pm
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm unit: compares the 12-hour BCD time against a programmable alarm
// (or snooze) target, rings on a fresh match, and handles snooze, dismiss,
// auto-timeout and alarm programming.
module alarm_controller #(
  parameter logic [7:0] SNOOZE_MIN   = 8'h09,
  parameter int         RING_MINUTES = 5,
  parameter int         MAX_SNOOZE   = 3
) (
  input  logic   clk,
  input  logic   reset,
  alarm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic       p;
  } hmp_t;

  // BCD value with both nibbles decimal and inside [lo, hi]
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  // 12-hour BCD hour increment; the AM/PM flip at 11->12 is handled by the caller
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h12) begin
      r = 8'h01;
    end else if (h[3:0] == 4'h9) begin
      r = {h[7:4] + 4'h1, 4'h0};
    end else begin
      r = {h[7:4], h[3:0] + 4'h1};
    end
    return r;
  endfunction

  // Current time plus SNOOZE_MIN minutes, with minute carry into the hour
  function automatic hmp_t snooze_add(input logic [7:0] h, input logic [7:0] m,
                                      input logic p);
    hmp_t        r;
    int unsigned mins;
    mins = 32'(m[7:4]) * 32'd10 + 32'(m[3:0])
         + 32'(SNOOZE_MIN[7:4]) * 32'd10 + 32'(SNOOZE_MIN[3:0]);
    r.h = h;
    r.p = p;
    if (mins >= 32'd60) begin
      mins = mins - 32'd60;
      r.h  = hour_inc(h);
      if (h == 8'h11) begin
        r.p = ~p;
      end
    end
    r.m = {4'(mins / 32'd10), 4'(mins % 32'd10)};
    return r;
  endfunction

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] rmin;
  logic       ring_q, snoozing_q, ring_d, snoozing_d;
  logic       set_err_q;
  logic [7:0] al_hh_q, al_mm_q;
  logic       al_pm_q;
  logic [7:0] sz_hh, sz_mm;
  logic       sz_pm;
  logic       match_q;
  logic [7:0] ss_q;

  logic [7:0] tgt_hh, tgt_mm;
  logic       tgt_pm;
  logic       match, hit, minute_tick, set_ok, ring_timeout, load_snz;
  hmp_t       snz_next;

  // Compare target selection, edge detect on match, minute tick and set validation
  always_comb begin
    tgt_hh       = (state == SNOOZE) ? sz_hh : al_hh_q;
    tgt_mm       = (state == SNOOZE) ? sz_mm : al_mm_q;
    tgt_pm       = (state == SNOOZE) ? sz_pm : al_pm_q;
    match        = (bus.hh == tgt_hh) && (bus.mm == tgt_mm) && (bus.pm == tgt_pm)
                && (bus.ss == 8'h00);
    hit          = match && !match_q;
    minute_tick  = (bus.ss == 8'h00) && (ss_q == 8'h59);
    set_ok       = bus.set_en && bcd_in_range(bus.set_hh, 8'h01, 8'h12)
                && bcd_in_range(bus.set_mm, 8'h00, 8'h59);
    ring_timeout = minute_tick && ((int'(rmin) + 1) >= RING_MINUTES);
    snz_next     = snooze_add(bus.hh, bus.mm, bus.pm);
  end

  // Next-state logic; arm dominates, then programming, then user strobes, then events
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load_snz = 1'b0;
    if (!bus.arm) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
    end else if (bus.set_en) begin
      if (set_ok && ((state == RINGING) || (state == SNOOZE))) begin
        state_nx = ARMED;
        cnt_nx   = 4'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          state_nx = ARMED;
        end
        ARMED: begin
          if (hit) begin
            state_nx = RINGING;
          end
        end
        RINGING: begin
          if (bus.dismiss) begin
            state_nx = ARMED;
            cnt_nx   = 4'd0;
          end else if (bus.snooze && (int'(cnt) < MAX_SNOOZE)) begin
            state_nx = SNOOZE;
            cnt_nx   = cnt + 4'd1;
            load_snz = 1'b1;
          end else if (ring_timeout) begin
            state_nx = ARMED;
            cnt_nx   = 4'd0;
          end
        end
        SNOOZE: begin
          if (bus.dismiss) begin
            state_nx = ARMED;
            cnt_nx   = 4'd0;
          end else if (hit) begin
            state_nx = RINGING;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so ring/snoozing leave a register
  always_comb begin
    ring_d     = (state_nx == RINGING);
    snoozing_d = (state_nx == SNOOZE);
  end

  // State register, snooze counter and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
    end
  end

  // Alarm time storage and one-cycle rejection pulse for bad programming
  always_ff @(posedge clk) begin
    if (reset) begin
      al_hh_q   <= 8'h12;
      al_mm_q   <= 8'h00;
      al_pm_q   <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= bus.set_en && !set_ok;
      if (set_ok) begin
        al_hh_q <= bus.set_hh;
        al_mm_q <= bus.set_mm;
        al_pm_q <= bus.set_pm;
      end
    end
  end

  // Previous-cycle match and seconds, tracked in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
      ss_q    <= 8'h00;
    end else begin
      match_q <= match;
      ss_q    <= bus.ss;
    end
  end

  // Ring duration in minute ticks; held at zero whenever not ringing
  always_ff @(posedge clk) begin
    if (reset) begin
      rmin <= 4'd0;
    end else if (state == RINGING) begin
      if (minute_tick) begin
        rmin <= rmin + 4'd1;
      end
    end else begin
      rmin <= 4'd0;
    end
  end

  // Snooze target captured when a snooze is accepted; only read in SNOOZE
  always_ff @(posedge clk) begin
    if (load_snz) begin
      sz_hh <= snz_next.h;
      sz_mm <= snz_next.m;
      sz_pm <= snz_next.p;
    end
  end

  assign bus.ring       = ring_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = cnt;
  assign bus.set_err    = set_err_q;
  assign bus.al_hh      = al_hh_q;
  assign bus.al_mm      = al_mm_q;
  assign bus.al_pm      = al_pm_q;

endmodule
